vga_pattern_gen: RTL and testbench

- Pixel-colour stage directly downstream of the 640x480 VGA timing controller.
- Consumes its column/row counters, display-active flag and sync pulses, and drives the 4:4:4 RGB pins of the board VGA port.
- Generates four selectable test patterns, including a bouncing box that moves once per frame.
- Delays both syncs to match the RGB pipeline, so monitor timing is preserved.

---
 rtl/vga_pkg.sv | 62 ++++++
 rtl/vga_box_mover.sv | 43 ++++
 rtl/vga_pattern_gen.sv | 136 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared display geometry, RGB444 colours, pattern modes and the
//           per-axis bounce step used by the pattern generator.
// Rev     : 1.0  initial release
// ============================================================================
package vga_pkg;

   localparam int H_DISP = 640;
   localparam int V_DISP = 480;

   localparam logic [11:0] WHITE   = 12'hFFF;
   localparam logic [11:0] YELLOW  = 12'hFF0;
   localparam logic [11:0] CYAN    = 12'h0FF;
   localparam logic [11:0] GREEN   = 12'h0F0;
   localparam logic [11:0] MAGENTA = 12'hF0F;
   localparam logic [11:0] RED     = 12'hF00;
   localparam logic [11:0] BLUE    = 12'h00F;
   localparam logic [11:0] BLACK   = 12'h000;

   localparam logic [1:0] MODE_BARS  = 2'd0;
   localparam logic [1:0] MODE_CHECK = 2'd1;
   localparam logic [1:0] MODE_BOX   = 2'd2;
   localparam logic [1:0] MODE_GRAD  = 2'd3;

   typedef enum logic {
      DIR_INC = 1'b0,
      DIR_DEC = 1'b1
   } dir_t;

   typedef struct packed {
      dir_t       dir;
      logic [9:0] pos;
   } axis_t;

   // One frame of motion on one axis; the box clamps to the wall and reverses.
   function automatic axis_t bounce_step(input axis_t cur,
                                         input logic [9:0] max_pos,
                                         input logic [9:0] step);
      axis_t nxt;
      nxt = cur;
      if (cur.dir == DIR_INC) begin
         if (cur.pos >= max_pos - step) begin
            nxt.pos = max_pos;
            nxt.dir = DIR_DEC;
         end else begin
            nxt.pos = cur.pos + step;
         end
      end else begin
         if (cur.pos <= step) begin
            nxt.pos = '0;
            nxt.dir = DIR_INC;
         end else begin
            nxt.pos = cur.pos - step;
         end
      end
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_box_mover.sv
`default_nettype none
// ============================================================================
// Module  : vga_box_mover
// Purpose : Holds the bouncing-box position and direction, advanced once per
//           frame tick.
// Rev     : 1.0  initial release
// ============================================================================
module vga_box_mover #(
   parameter int H_DISP   = 640,
   parameter int V_DISP   = 480,
   parameter int BOX_SIZE = 32,
   parameter int STEP     = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tick,
   output logic [9:0] box_x,
   output logic [9:0] box_y
);
   import vga_pkg::*;

   localparam logic [9:0] X_MAX  = 10'(H_DISP - BOX_SIZE);
   localparam logic [9:0] Y_MAX  = 10'(V_DISP - BOX_SIZE);
   localparam logic [9:0] STEP_W = 10'(STEP);

   axis_t x_q;
   axis_t y_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_q <= '{dir: DIR_INC, pos: 10'd0};
         y_q <= '{dir: DIR_INC, pos: 10'd0};
      end else if (tick) begin
         x_q <= bounce_step(x_q, X_MAX, STEP_W);
         y_q <= bounce_step(y_q, Y_MAX, STEP_W);
      end
   end

   assign box_x = x_q.pos;
   assign box_y = y_q.pos;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_pattern_gen
// Purpose : Two-stage RGB444 test-pattern generator behind the 640x480 timing
//           controller; syncs are delayed to stay aligned with the colour.
// Rev     : 1.0  initial release
// ============================================================================
module vga_pattern_gen #(
   parameter int H_DISP     = 640,
   parameter int V_DISP     = 480,
   parameter int BOX_SIZE   = 32,
   parameter int STEP       = 4,
   parameter int CHECK_LOG2 = 5,
   parameter int BAR_W      = 80
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       hsync_i,
   input  logic       vsync_i,
   input  logic       disp_active_i,
   input  logic [9:0] xcol_i,
   input  logic [9:0] yrow_i,
   input  logic [1:0] mode_i,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic [3:0] red_o,
   output logic [3:0] green_o,
   output logic [3:0] blue_o
);
   import vga_pkg::*;

   logic       tick;
   logic [9:0] x_s1;
   logic [9:0] y_s1;
   logic       act_s1;
   logic       hs_s1;
   logic       vs_s1;
   logic [1:0] mode_q;
   logic [7:0] frame_cnt;
   logic [9:0] box_x;
   logic [9:0] box_y;
   logic [10:0] box_x_end;
   logic [10:0] box_y_end;
   logic       in_box;
   logic [11:0] colour;
   logic [11:0] rgb_q;

   // First blanking line, first column: the frame boundary.
   assign tick = (xcol_i == 10'd0) && (yrow_i == 10'(V_DISP));

   function automatic logic [11:0] bar_colour(input logic [9:0] x);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (x >= 10'(i * BAR_W)) idx = 3'(i);
      end
      case (idx)
         3'd0:    return WHITE;
         3'd1:    return YELLOW;
         3'd2:    return CYAN;
         3'd3:    return GREEN;
         3'd4:    return MAGENTA;
         3'd5:    return RED;
         3'd6:    return BLUE;
         default: return BLACK;
      endcase
   endfunction

   vga_box_mover #(
      .H_DISP   (H_DISP),
      .V_DISP   (V_DISP),
      .BOX_SIZE (BOX_SIZE),
      .STEP     (STEP)
   ) u_box_mover (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .tick  (tick),
      .box_x (box_x),
      .box_y (box_y)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_s1      <= '0;
         y_s1      <= '0;
         act_s1    <= 1'b0;
         hs_s1     <= 1'b1;
         vs_s1     <= 1'b1;
         mode_q    <= MODE_BARS;
         frame_cnt <= '0;
      end else begin
         x_s1   <= xcol_i;
         y_s1   <= yrow_i;
         act_s1 <= disp_active_i;
         hs_s1  <= hsync_i;
         vs_s1  <= vsync_i;
         if (tick) begin
            mode_q    <= mode_i;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   assign box_x_end = {1'b0, box_x} + 11'(BOX_SIZE);
   assign box_y_end = {1'b0, box_y} + 11'(BOX_SIZE);
   assign in_box    = (x_s1 >= box_x) && ({1'b0, x_s1} < box_x_end) &&
                      (y_s1 >= box_y) && ({1'b0, y_s1} < box_y_end);

   always_comb begin
      colour = BLACK;
      case (mode_q)
         MODE_BARS:  colour = bar_colour(x_s1);
         MODE_CHECK: colour = (x_s1[CHECK_LOG2] ^ y_s1[CHECK_LOG2]) ? WHITE : BLACK;
         MODE_BOX:   colour = in_box ? WHITE : BLUE;
         default:    colour = {x_s1[8:5], y_s1[8:5], frame_cnt[7:4]};
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rgb_q   <= BLACK;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
      end else begin
         rgb_q   <= act_s1 ? colour : BLACK;
         hsync_o <= hs_s1;
         vsync_o <= vs_s1;
      end
   end

   assign red_o   = rgb_q[11:8];
   assign green_o = rgb_q[7:4];
   assign blue_o  = rgb_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_pattern_gen
// Purpose : Self-checking bench: directed pattern/bounce/reset probes plus a
//           randomized run against a behavioural frame model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vga_pattern_gen;

   localparam int H  = 640;
   localparam int V  = 480;
   localparam int BS = 32;
   localparam int ST = 4;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       hsync_i = 1'b1;
   logic       vsync_i = 1'b1;
   logic       disp_active_i = 1'b0;
   logic [9:0] xcol_i = '0;
   logic [9:0] yrow_i = '0;
   logic [1:0] mode_i = '0;
   logic       hsync_o;
   logic       vsync_o;
   logic [3:0] red_o;
   logic [3:0] green_o;
   logic [3:0] blue_o;

   vga_pattern_gen dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .hsync_i       (hsync_i),
      .vsync_i       (vsync_i),
      .disp_active_i (disp_active_i),
      .xcol_i        (xcol_i),
      .yrow_i        (yrow_i),
      .mode_i        (mode_i),
      .hsync_o       (hsync_o),
      .vsync_o       (vsync_o),
      .red_o         (red_o),
      .green_o       (green_o),
      .blue_o        (blue_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // Behavioural frame state
   int m_mode, m_fc, m_bx, m_by, m_dx, m_dy;
   int mode_sel = 0;
   logic [13:0] exp_prev;
   bit          exp_valid = 1'b0;
   logic [11:0] bar_tab [8];

   task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [13:0] outs();
      return {hsync_o, vsync_o, red_o, green_o, blue_o};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
   endtask

   task automatic move_axis(inout int pos, inout int dir, input int lim);
      int np;
      np = pos + dir * ST;
      if (np >= lim - BS) begin
         pos = lim - BS; dir = -1;
      end else if (np <= 0) begin
         pos = 0; dir = 1;
      end else begin
         pos = np;
      end
   endtask

   task automatic model_tick(input int m);
      m_mode = m;
      m_fc   = (m_fc + 1) % 256;
      move_axis(m_bx, m_dx, H);
      move_axis(m_by, m_dy, V);
   endtask

   function automatic logic [11:0] model_rgb(input int x, input int y, input bit act);
      int idx;
      if (!act) return 12'h000;
      case (m_mode)
         0: begin
            idx = x / 80;
            if (idx > 7) idx = 7;
            return bar_tab[idx];
         end
         1: return ((((x / 32) % 2) != ((y / 32) % 2))) ? 12'hFFF : 12'h000;
         2: return (x >= m_bx && x < m_bx + BS && y >= m_by && y < m_by + BS) ? 12'hFFF : 12'h00F;
         default: return {4'((x / 32) % 16), 4'((y / 32) % 16), 4'((m_fc / 16) % 16)};
      endcase
   endfunction

   // Drive one pixel, clock it, and compare the output with the pixel of the previous cycle.
   task automatic cycle(input bit hs, input bit vs, input bit act, input int x, input int y);
      logic [13:0] now;
      hsync_i = hs; vsync_i = vs; disp_active_i = act;
      xcol_i = 10'(x); yrow_i = 10'(y); mode_i = 2'(mode_sel);
      @(posedge clk_i);
      if (x == 0 && y == V) model_tick(mode_sel);
      now = {hs, vs, model_rgb(x, y, act)};
      #1;
      if (exp_valid) check("pipe", outs(), exp_prev);
      exp_prev  = now;
      exp_valid = 1'b1;
   endtask

   task automatic tick_frame();
      cycle(1'b1, 1'b1, 1'b0, 0, V);
   endtask

   task automatic probe(input string tag, input int x, input int y, input bit act, input logic [11:0] exp);
      cycle(1'b1, 1'b1, act, x, y);
      cycle(1'b1, 1'b1, 1'b0, 1, 1);
      check(tag, outs(), {2'b11, exp});
   endtask

   task automatic release_reset();
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      model_reset();
      exp_prev  = 14'h3000;
      exp_valid = 1'b1;
   endtask

   initial begin
      bar_tab[0] = 12'hFFF; bar_tab[1] = 12'hFF0; bar_tab[2] = 12'h0FF; bar_tab[3] = 12'h0F0;
      bar_tab[4] = 12'hF0F; bar_tab[5] = 12'hF00; bar_tab[6] = 12'h00F; bar_tab[7] = 12'h000;
      model_reset();

      @(posedge clk_i);
      #1;
      check("reset_state", outs(), 14'h3000);
      release_reset();

      // Colour bars and blanking
      probe("bar_x0",   0,   0, 1'b1, 12'hFFF);
      probe("bar_x80",  80,  0, 1'b1, 12'hFF0);
      probe("bar_x639", 639, 0, 1'b1, 12'h000);
      probe("bar_x160", 160, 5, 1'b1, 12'h0FF);
      probe("bar_x400", 400, 7, 1'b1, 12'hF00);
      probe("blank",    100, 100, 1'b0, 12'h000);

      // Sync latency
      cycle(1'b0, 1'b1, 1'b1, 10, 10);
      check("hs_lat1", {13'd0, hsync_o}, 14'd1);
      cycle(1'b1, 1'b1, 1'b1, 11, 10);
      check("hs_lat2", {13'd0, hsync_o}, 14'd0);

      // Checkerboard
      mode_sel = 1;
      tick_frame();
      probe("chk_31_0",  31, 0,  1'b1, 12'h000);
      probe("chk_32_0",  32, 0,  1'b1, 12'hFFF);
      probe("chk_32_32", 32, 32, 1'b1, 12'h000);

      // Mode change mid-frame waits for the frame tick
      mode_sel = 0;
      tick_frame();
      mode_sel = 1;
      probe("midframe_bar", 80, 100, 1'b1, 12'hFF0);
      probe("midframe_bar2", 32, 200, 1'b1, 12'hFFF);
      tick_frame();
      probe("newframe_chk", 32, 0, 1'b1, 12'hFFF);
      probe("newframe_chk2", 31, 0, 1'b1, 12'h000);

      // Asynchronous reset mid-frame
      cycle(1'b0, 1'b0, 1'b1, 32, 0);
      cycle(1'b0, 1'b0, 1'b1, 32, 0);
      #2;
      rst_i = 1'b1;
      #1;
      check("async_rst", outs(), 14'h3000);
      release_reset();
      probe("post_rst_bars", 80, 0, 1'b1, 12'hFF0);

      // Bouncing box
      mode_sel = 2;
      for (int t = 1; t <= 153; t++) begin
         tick_frame();
         if (t == 112) begin
            probe("box_y448_in",  448, 448, 1'b1, 12'hFFF);
            probe("box_y448_out", 448, 447, 1'b1, 12'h00F);
         end
         if (t == 113) begin
            probe("box_y444_in",  452, 444, 1'b1, 12'hFFF);
            probe("box_y444_out", 452, 443, 1'b1, 12'h00F);
         end
         if (t == 152) begin
            probe("box_x608_in",   608, 288, 1'b1, 12'hFFF);
            probe("box_x608_left", 607, 288, 1'b1, 12'h00F);
            probe("box_x608_far",  639, 319, 1'b1, 12'hFFF);
            probe("box_y320_out",  620, 320, 1'b1, 12'h00F);
         end
      end
      probe("box_x604_in",  604, 284, 1'b1, 12'hFFF);
      probe("box_x604_out", 636, 284, 1'b1, 12'h00F);

      // Randomized pixels against the frame model
      for (int n = 0; n < 4000; n++) begin
         int r, x, y;
         if (n % 400 == 0) mode_sel = int'($urandom_range(0, 3));
         r = int'($urandom_range(0, 99));
         if (r < 4) begin
            tick_frame();
         end else begin
            case ($urandom_range(0, 4))
               0: x = 639 + int'($urandom_range(0, 1));
               1: x = 80 * int'($urandom_range(0, 8)) - int'($urandom_range(0, 1));
               default: x = int'($urandom_range(0, 799));
            endcase
            if (x < 0) x = 0;
            y = ($urandom_range(0, 5) == 0) ? 479 + int'($urandom_range(0, 1))
                                            : int'($urandom_range(0, 524));
            if (x == 0 && y == V) y = V + 1;
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  (x < H && y < V), x, y);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
